// File: rtl/systolic_drain_deskew.sv
// Drains the skewed result buffer, deskews the columns and streams one aligned row per cycle (ReLU clamp when SYSTOLIC_DRAIN_RELU_EN is defined).
// Latency: first row valid N_SIZE+1 cycles after start. Backpressure: out_valid && !out_ready freezes address, delay lines and output.
module systolic_drain_deskew #(
   parameter int DATAWIDTH_output = 32,
   parameter int N_SIZE           = 32,
   parameter int NUM_ROWS         = 512,
   parameter int DEPTH            = 543,
   parameter int ADDR_WIDTH       = 10
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [ADDR_WIDTH-1:0]              row_count,
   output logic [ADDR_WIDTH-1:0]              rd_addr,
   input  logic [DATAWIDTH_output*N_SIZE-1:0] buf_data,
   output logic [DATAWIDTH_output*N_SIZE-1:0] out_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               out_last,
   output logic                               busy,
   output logic                               done
);
   localparam int DW = DATAWIDTH_output;
   localparam int BW = DATAWIDTH_output * N_SIZE;
   localparam logic [ADDR_WIDTH-1:0] LP_ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] LP_PRIME = ADDR_WIDTH'(N_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] LP_NROWS = ADDR_WIDTH'(NUM_ROWS);
   localparam logic [ADDR_WIDTH-1:0] LP_AMAX  = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_t;

   state_t                r_state, w_nxt;
   logic [ADDR_WIDTH-1:0] r_cur, r_last, w_rd_addr, w_rows, w_last_raw;
   logic [BW-1:0]         r_out_data, w_row;
   logic                  r_out_vld, r_out_last, r_busy, r_done;
   logic                  w_adv, w_at_last, w_shift, w_load;
   logic [DW-1:0]         w_col [N_SIZE];

   assign w_adv      = !r_out_vld || out_ready;
   assign w_at_last  = (r_cur == r_last);
   assign w_shift    = (r_state == S_DRAIN) && w_adv;
   assign w_load     = w_shift && (r_cur >= LP_PRIME);
   assign w_rows     = (row_count > LP_NROWS) ? LP_NROWS : row_count;
   assign w_last_raw = w_rows + LP_PRIME - LP_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   // r_cur doubles as the consumed-word count: the word on buf_data is always word r_cur.
   always_comb begin
      w_nxt     = r_state;
      w_rd_addr = '0;
      case (r_state)
         S_IDLE: begin
            if (start && row_count != '0) w_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            w_rd_addr = (w_adv && !w_at_last) ? r_cur + LP_ONE : r_cur;
            if (w_adv && w_at_last) w_nxt = S_FLUSH;
         end
         S_FLUSH: begin
            w_rd_addr = r_last;
            if (r_out_vld && out_ready) w_nxt = S_IDLE;
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   for (genvar j = 0; j < N_SIZE; j++) begin : g_col
      localparam int D = N_SIZE - 1 - j;
      if (D == 0) begin : g_nodly
         assign w_col[j] = buf_data[j*DW +: DW];
      end else begin : g_dly
         logic [DW-1:0] r_sh [D];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < D; i++) r_sh[i] <= '0;
            end else if (w_shift) begin
               r_sh[0] <= buf_data[j*DW +: DW];
               for (int i = 1; i < D; i++) r_sh[i] <= r_sh[i-1];
            end
         end
         assign w_col[j] = r_sh[D-1];
      end
   end

   always_comb begin
      w_row = '0;
      for (int j = 0; j < N_SIZE; j++) begin
`ifdef SYSTOLIC_DRAIN_RELU_EN
         w_row[j*DW +: DW] = w_col[j][DW-1] ? '0 : w_col[j];
`else
         w_row[j*DW +: DW] = w_col[j];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur      <= '0;
         r_last     <= '0;
         r_out_data <= '0;
         r_out_vld  <= 1'b0;
         r_out_last <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_busy <= (w_nxt != S_IDLE);
         r_done <= ((r_state == S_IDLE) && start && row_count == '0) ||
                   ((r_state == S_FLUSH) && r_out_vld && out_ready);
         if ((r_state == S_IDLE) && start) begin
            r_cur  <= '0;
            r_last <= (w_last_raw > LP_AMAX) ? LP_AMAX : w_last_raw;
         end else if (w_shift && !w_at_last) begin
            r_cur <= r_cur + LP_ONE;
         end
         if (w_load) begin
            r_out_data <= w_row;
            r_out_vld  <= 1'b1;
            r_out_last <= w_at_last;
         end else if (out_ready) begin
            r_out_vld  <= 1'b0;
            r_out_last <= 1'b0;
         end
      end
   end

   assign rd_addr   = w_rd_addr;
   assign out_data  = r_out_data;
   assign out_valid = r_out_vld;
   assign out_last  = r_out_last;
   assign busy      = r_busy;
   assign done      = r_done;
endmodule

// File: tb/tb_systolic_drain_deskew.sv
// Randomized bench for systolic_drain_deskew: rows are built from a skewed buffer image and checked against the unskewed source table.
module tb_systolic_drain_deskew;
   localparam int DW = 32;
   localparam int N  = 4;
   localparam int NR = 16;
   localparam int DP = NR + N - 1;
   localparam int AW = 10;
   localparam int BW = DW * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] row_count = '0;
   logic [AW-1:0] rd_addr;
   logic [BW-1:0] buf_data = '0;
   logic [BW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic          busy;
   logic          done;

   logic [BW-1:0] mem [DP];
   logic [DW-1:0] ex  [NR][N];
   int            cyc = 0;
   int            n_total = 0;
   int            n_bad = 0;

   systolic_drain_deskew #(
      .DATAWIDTH_output(DW), .N_SIZE(N), .NUM_ROWS(NR), .DEPTH(DP), .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .row_count(row_count),
      .rd_addr(rd_addr), .buf_data(buf_data), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) buf_data <= mem[rd_addr];

   task automatic chk_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef SYSTOLIC_DRAIN_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [BW-1:0] row_exp(input int r);
      logic [BW-1:0] e;
      e = '0;
      for (int j = 0; j < N; j++) e[j*DW +: DW] = ex[r][j];
      return e;
   endfunction

   // Element (r,j) lives at address r+j, column j; everything else is junk that must never surface.
   task automatic fill(input int rows, input int mode);
      logic [DW-1:0] v;
      for (int a = 0; a < DP; a++)
         for (int j = 0; j < N; j++) mem[a][j*DW +: DW] = $urandom;
      for (int r = 0; r < rows; r++)
         for (int j = 0; j < N; j++) begin
            v = (mode == 0) ? DW'(16*r + j) : DW'($urandom);
            if (mode == 1 && r == 0 && j == 1) v = 32'hFFFF_FFF6;
            if (mode == 1 && r == 0 && j == 2) v = 32'h0000_0007;
            mem[r+j][j*DW +: DW] = v;
            ex[r][j] = relu(v);
         end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk_eq({tag, "_vld"},  out_valid, 0);
      chk_eq({tag, "_data"}, out_data, 0);
      chk_eq({tag, "_last"}, out_last, 0);
      chk_eq({tag, "_busy"}, busy, 0);
      chk_eq({tag, "_done"}, done, 0);
      chk_eq({tag, "_addr"}, rd_addr, 0);
   endtask

   task automatic run_drain(input int rows, input int mode, input bit bp,
                            input int abort_at, input int restart_at);
      int t0, c, n, last_c, max_addr;
      bit got_done, prev_stall, stall;
      logic [BW-1:0] prev_data;
      logic [AW-1:0] prev_addr;
      fill(rows, mode);
      n = 0; last_c = -1; max_addr = 0; got_done = 0; prev_stall = 0;
      prev_data = '0; prev_addr = '0;
      @(posedge clk); #1;
      start = 1'b1; row_count = AW'(rows);
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      t0 = cyc;
      for (int it = 0; it < 400 && !got_done; it++) begin
         @(negedge clk);
         c = cyc - t0;
         if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
         if (c == 1) chk_eq("busy_c1", busy, 1);
         stall = out_valid && !out_ready;
         if (prev_stall) chk_eq("stall_data", out_data, prev_data);
         if (prev_stall && stall) chk_eq("stall_addr", rd_addr, prev_addr);
         prev_stall = stall; prev_data = out_data; prev_addr = rd_addr;
         if (out_valid && out_ready) begin
            if (n < rows) chk_eq("row_data", out_data, row_exp(n));
            else          chk_eq("extra_row", n, rows - 1);
            chk_eq("last_flag", out_last, (n == rows - 1));
            if (!bp && n == 0)        chk_eq("first_cyc", c, N + 1);
            if (!bp && n == rows - 1) chk_eq("last_cyc", c, rows + N);
            last_c = c;
            n++;
         end
         if (done) begin
            got_done = 1'b1;
            chk_eq("done_cnt", n, rows);
            chk_eq("done_cyc", c, last_c + 1);
            chk_eq("busy_at_done", busy, 0);
            chk_eq("vld_at_done", out_valid, 0);
         end else begin
            @(posedge clk); #1;
            start = (restart_at >= 0 && c + 1 == restart_at);
            if (start) row_count = AW'(3);
            out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (abort_at >= 0 && n == abort_at) begin
               start = 1'b0;
               rst_n = 1'b0;
               #1;
               chk_idle_outputs("abort");
               repeat (3) begin
                  @(negedge clk);
                  chk_eq("abort_no_done", done, 0);
                  chk_eq("abort_no_vld", out_valid, 0);
               end
               rst_n = 1'b1;
               return;
            end
         end
      end
      chk_eq("timeout", got_done, 1);
      chk_eq("rd_max", max_addr, rows + N - 2);
   endtask

   task automatic zero_start();
      @(posedge clk); #1;
      start = 1'b1; row_count = '0;
      @(negedge clk);
      chk_eq("zero_busy0", busy, 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk_eq("zero_done", done, 1);
      chk_eq("zero_busy1", busy, 0);
      chk_eq("zero_vld", out_valid, 0);
      @(negedge clk);
      chk_eq("zero_done_pulse", done, 0);
   endtask

   initial begin
      for (int a = 0; a < DP; a++) mem[a] = '0;
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      run_drain(8, 0, 1'b0, -1, -1);
      run_drain(8, 0, 1'b1, -1, -1);
      run_drain(1, 0, 1'b0, -1, -1);
      zero_start();
      run_drain(8, 0, 1'b0, 3, -1);
      run_drain(8, 0, 1'b0, -1, -1);
      run_drain(5, 1, 1'b1, -1, -1);
      run_drain(8, 0, 1'b0, -1, 3);
      for (int t = 0; t < 6; t++) run_drain($urandom_range(1, NR), 1, 1'b1, -1, -1);
      run_drain(NR, 1, 1'b0, -1, -1);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
